// File: rtl/jellyvl_etherneco_synctimer_scheduler.sv
// EtherNeco synctimer master scheduler: periodic sync command packets out,
// per-node elapsed times back in, round-trip based per-node offsets computed.
module jellyvl_etherneco_synctimer_scheduler #(
    parameter int unsigned TIMER_WIDTH  = 64,
    parameter int unsigned MAX_NODES    = 8,
    parameter int unsigned PERIOD_WIDTH = 32,
    parameter int unsigned TIMEOUT      = 65535,
    parameter int unsigned TX_LATENCY   = 0,
    parameter int signed   OFFSET_BIAS  = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic [7:0]              node_count,
    input  logic                    override_req,
    input  logic [TIMER_WIDTH-1:0]  current_time,
    output logic                    m_cmd_first,
    output logic                    m_cmd_last,
    output logic [7:0]              m_cmd_data,
    output logic                    m_cmd_valid,
    input  logic                    m_cmd_ready,
    input  logic                    res_rx_start,
    input  logic                    res_rx_end,
    input  logic                    res_rx_error,
    input  logic [15:0]             s_res_pos,
    input  logic [7:0]              s_res_data,
    input  logic                    s_res_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic                    overrun
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_RES = 2'd2,
        ST_UPDATE   = 2'd3
    } state_t;

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
    logic                    pending_q, pending_d;
    logic                    ovr_q, ovr_d;
    logic                    overrun_q, overrun_d;
    logic                    error_q, error_d;
    logic                    done_q, done_d;
    logic [7:0]              n_q, n_d;
    logic [63:0]             t0_q, t0_d;
    logic [7:0]              cmd_q, cmd_d;
    logic [15:0]             idx_q, idx_d;
    logic                    vld_q, vld_d;
    logic                    first_q, first_d;
    logic                    last_q, last_d;
    logic [7:0]              data_q, data_d;
    logic [31:0]             tx_start_q, tx_start_d;
    logic [31:0]             rtt_q, rtt_d;
    logic [31:0]             wait_q, wait_d;
    logic [7:0]              upd_q, upd_d;
    logic [31:0]             offset_q  [MAX_NODES];
    logic [31:0]             offset_d  [MAX_NODES];
    logic [31:0]             elapsed_q [MAX_NODES];
    logic [31:0]             elapsed_d [MAX_NODES];

    logic                    trig;
    logic                    consume;
    logic                    hs;
    logic [PERIOD_WIDTH-1:0] period_m1;
    logic [7:0]              n_clamp;
    logic [15:0]             pkt_len;
    logic [15:0]             rel_tx;
    logic [15:0]             rel_rx;
    logic [2:0]              t0_sel;
    logic [7:0]              ld_byte;
    logic [31:0]             diff;

    assign m_cmd_valid = vld_q;
    assign m_cmd_first = first_q;
    assign m_cmd_last  = last_q;
    assign m_cmd_data  = data_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign error       = error_q;
    assign overrun     = overrun_q;

    // Byte that the output register loads for packet position idx_q.
    always_comb begin
        ld_byte = 8'h00;
        rel_tx  = idx_q - 16'd9;
        t0_sel  = 3'(idx_q - 16'd1);
        if (idx_q == 16'd0) begin
            ld_byte = cmd_q;
        end else if (idx_q < 16'd9) begin
            ld_byte = 8'(t0_q >> {t0_sel, 3'b000});
        end else begin
            for (int n = 0; n < MAX_NODES; n++) begin
                if (rel_tx[15:2] == 14'(n)) begin
                    ld_byte = 8'(offset_q[n] >> {rel_tx[1:0], 3'b000});
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        overrun_d  = overrun_q;
        error_d    = error_q;
        done_d     = 1'b0;
        n_d        = n_q;
        t0_d       = t0_q;
        cmd_d      = cmd_q;
        idx_d      = idx_q;
        vld_d      = vld_q;
        first_d    = first_q;
        last_d     = last_q;
        data_d     = data_q;
        tx_start_d = tx_start_q;
        rtt_d      = rtt_q;
        wait_d     = wait_q;
        upd_d      = upd_q;
        offset_d   = offset_q;
        elapsed_d  = elapsed_q;
        consume    = 1'b0;
        diff       = 32'd0;
        hs         = vld_q & m_cmd_ready;
        rel_rx     = s_res_pos - 16'd9;

        // >= rather than == so that shrinking period mid-count still wraps promptly
        period_m1 = (period == '0) ? '0 : period - PERIOD_WIDTH'(1);
        trig      = enable && (cnt_q >= period_m1);
        cnt_d     = (enable && !trig) ? cnt_q + PERIOD_WIDTH'(1) : '0;

        if (node_count == 8'd0)                 n_clamp = 8'd1;
        else if (node_count > 8'(MAX_NODES))    n_clamp = 8'(MAX_NODES);
        else                                    n_clamp = node_count;
        pkt_len = 16'd9 + {6'b0, n_q, 2'b00};

        case (state_q)
            ST_IDLE: begin
                if (pending_q && enable) begin
                    consume = 1'b1;
                    error_d = 1'b0;
                    n_d     = n_clamp;
                    t0_d    = 64'(current_time + TIMER_WIDTH'(TX_LATENCY));
                    cmd_d   = {6'b0, ovr_q, 1'b1};
                    idx_d   = 16'd0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (hs && first_q) tx_start_d = current_time[31:0];
                if (!vld_q || m_cmd_ready) begin
                    if (hs && last_q) begin
                        vld_d   = 1'b0;
                        first_d = 1'b0;
                        last_d  = 1'b0;
                        data_d  = 8'h00;
                        wait_d  = 32'd0;
                        state_d = ST_WAIT_RES;
                    end else if (idx_q < pkt_len) begin
                        vld_d   = 1'b1;
                        data_d  = ld_byte;
                        first_d = (idx_q == 16'd0);
                        last_d  = (idx_q == pkt_len - 16'd1);
                        idx_d   = idx_q + 16'd1;
                    end else begin
                        vld_d   = 1'b0;
                        first_d = 1'b0;
                        last_d  = 1'b0;
                    end
                end
            end
            ST_WAIT_RES: begin
                wait_d = wait_q + 32'd1;
                if (res_rx_start) rtt_d = current_time[31:0] - tx_start_q;
                if (s_res_valid && s_res_pos >= 16'd9) begin
                    for (int n = 0; n < MAX_NODES; n++) begin
                        if (rel_rx[15:2] == 14'(n) && 8'(n) < n_q) begin
                            elapsed_d[n] = (elapsed_q[n] & ~(32'hFF << {rel_rx[1:0], 3'b000}))
                                         | (32'(s_res_data) << {rel_rx[1:0], 3'b000});
                        end
                    end
                end
                if (res_rx_error || wait_q == TIMEOUT_LAST) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (res_rx_end) begin
                    upd_d   = 8'd0;
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                for (int n = 0; n < MAX_NODES; n++) begin
                    if (upd_q == 8'(n)) begin
                        diff        = rtt_q - elapsed_q[n];
                        offset_d[n] = 32'(signed'(diff) >>> 1) + 32'(OFFSET_BIAS);
                    end
                end
                upd_d = upd_q + 8'd1;
                if (upd_q == n_q - 8'd1) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A trigger landing on the cycle the pending one is consumed simply re-arms it.
        pending_d = trig | (pending_q & ~consume);
        if (trig && pending_q && !consume) overrun_d = 1'b1;
        ovr_d = consume ? override_req : (ovr_q | override_req);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pending_q  <= 1'b0;
            ovr_q      <= 1'b0;
            overrun_q  <= 1'b0;
            error_q    <= 1'b0;
            done_q     <= 1'b0;
            n_q        <= 8'd1;
            t0_q       <= 64'd0;
            cmd_q      <= 8'h00;
            idx_q      <= 16'd0;
            vld_q      <= 1'b0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            data_q     <= 8'h00;
            tx_start_q <= 32'd0;
            rtt_q      <= 32'd0;
            wait_q     <= 32'd0;
            upd_q      <= 8'd0;
            for (int n = 0; n < MAX_NODES; n++) begin
                offset_q[n]  <= 32'd0;
                elapsed_q[n] <= 32'd0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            ovr_q      <= ovr_d;
            overrun_q  <= overrun_d;
            error_q    <= error_d;
            done_q     <= done_d;
            n_q        <= n_d;
            t0_q       <= t0_d;
            cmd_q      <= cmd_d;
            idx_q      <= idx_d;
            vld_q      <= vld_d;
            first_q    <= first_d;
            last_q     <= last_d;
            data_q     <= data_d;
            tx_start_q <= tx_start_d;
            rtt_q      <= rtt_d;
            wait_q     <= wait_d;
            upd_q      <= upd_d;
            offset_q   <= offset_d;
            elapsed_q  <= elapsed_d;
        end
    end

endmodule

// File: tb/tb_jellyvl_etherneco_synctimer_scheduler.sv
// Scoreboard bench for the synctimer scheduler: expected packet bytes are queued
// from a behavioural offset model and checked by a monitor on each handshake.
module tb_jellyvl_etherneco_synctimer_scheduler;

    localparam int MAXN = 8;
    localparam int TMO  = 300;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] period = 32'd100;
    logic [7:0]  node_count = 8'd2;
    logic        override_req = 1'b0;
    logic [63:0] current_time;
    logic        m_cmd_first, m_cmd_last, m_cmd_valid;
    logic [7:0]  m_cmd_data;
    logic        m_cmd_ready = 1'b0;
    logic        res_rx_start = 1'b0, res_rx_end = 1'b0, res_rx_error = 1'b0;
    logic [15:0] s_res_pos = 16'd0;
    logic [7:0]  s_res_data = 8'd0;
    logic        s_res_valid = 1'b0;
    logic        busy, done, error, overrun;

    logic [63:0] cyc = 64'd0;
    logic [63:0] ct_ofs = 64'd0;
    int          rdy_mode = 1;

    assign current_time = cyc + ct_ofs;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 64'd1;

    always begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       m_cmd_ready = 1'b0;
            1:       m_cmd_ready = 1'b1;
            2:       m_cmd_ready = ~m_cmd_ready;
            default: m_cmd_ready = 1'($urandom % 2);
        endcase
    end

    jellyvl_etherneco_synctimer_scheduler #(
        .TIMER_WIDTH(64), .MAX_NODES(MAXN), .PERIOD_WIDTH(32),
        .TIMEOUT(TMO), .TX_LATENCY(0), .OFFSET_BIAS(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .period(period),
        .node_count(node_count), .override_req(override_req),
        .current_time(current_time),
        .m_cmd_first(m_cmd_first), .m_cmd_last(m_cmd_last), .m_cmd_data(m_cmd_data),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
        .res_rx_start(res_rx_start), .res_rx_end(res_rx_end), .res_rx_error(res_rx_error),
        .s_res_pos(s_res_pos), .s_res_data(s_res_data), .s_res_valid(s_res_valid),
        .busy(busy), .done(done), .error(error), .overrun(overrun)
    );

    typedef struct {
        bit         is_time;
        int         tbyte;
        logic [7:0] data;
        bit         first;
        bit         last;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] off_m[MAXN];
    logic [31:0] el_in[MAXN];
    bit          ovr_m = 0;
    int          cur_n = 1;
    bit          last_seen = 0;
    logic [31:0] tx_ct = 32'd0;
    logic [63:0] t0_exp = 64'd0;
    logic [63:0] first_valid_cyc = 64'd0;
    logic [63:0] last_hs_cyc = 64'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int clamp_n(input logic [7:0] n);
        if (n == 0) return 1;
        if (n > MAXN) return MAXN;
        return int'(n);
    endfunction

    function automatic longint floor2(input longint d);
        return (d >= 0) ? d / 2 : -((1 - d) / 2);
    endfunction

    function automatic exp_t mk(input bit is_t, input int tb, input logic [7:0] d,
                                input bit f, input bit l);
        exp_t e;
        e.is_time = is_t; e.tbyte = tb; e.data = d; e.first = f; e.last = l;
        return e;
    endfunction

    task automatic push_pkt();
        cur_n = clamp_n(node_count);
        q.push_back(mk(0, 0, ovr_m ? 8'h03 : 8'h01, 1, 0));
        ovr_m = 0;
        for (int k = 0; k < 8; k++) q.push_back(mk(1, k, 8'h00, 0, 0));
        for (int i = 0; i < cur_n; i++)
            for (int k = 0; k < 4; k++)
                q.push_back(mk(0, 0, 8'(off_m[i] >> (8 * k)), 0, (i == cur_n - 1) && (k == 3)));
        last_seen = 0;
    endtask

    task automatic wait_pkt();
        for (int i = 0; i < 3000 && !last_seen; i++) step();
        chk("packet_complete", {63'd0, last_seen}, 64'd1);
    endtask

    task automatic set_ct(input logic [63:0] v);
        ct_ofs = v - cyc;
    endtask

    // Drives a complete response; el_in holds the elapsed values per node.
    task automatic do_resp(input logic [31:0] rtt, input bit simul_end, input bit dbl_start);
        int          len;
        logic [63:0] ecyc;
        logic signed [31:0] dd;
        len = 9 + 4 * cur_n;
        if (dbl_start) begin
            set_ct({32'd0, tx_ct + $urandom});
            res_rx_start = 1; step(); res_rx_start = 0; step();
        end
        set_ct({32'd0, tx_ct + rtt});
        res_rx_start = 1; step(); res_rx_start = 0;
        for (int p = 0; p < len + 4; p++) begin
            if (p == len - 1) continue;
            s_res_valid = 1;
            s_res_pos   = 16'(p);
            s_res_data  = (p >= 9 && p < len) ? 8'(el_in[(p - 9) / 4] >> (8 * ((p - 9) % 4)))
                                              : 8'($urandom);
            step();
        end
        s_res_valid = 1;
        s_res_pos   = 16'(len - 1);
        s_res_data  = 8'(el_in[cur_n - 1] >> 24);
        res_rx_end  = simul_end;
        ecyc        = cyc;
        step();
        s_res_valid = 0;
        if (!simul_end) begin
            res_rx_end = 1; ecyc = cyc; step();
        end
        res_rx_end = 0;
        for (int i = 0; i < 60 && !done; i++) step();
        chk("done_latency", cyc - ecyc, 64'(cur_n + 1));
        chk("busy_at_done", {63'd0, busy}, 64'd0);
        for (int i = 0; i < cur_n; i++) begin
            dd = rtt - el_in[i];
            off_m[i] = 32'(floor2(longint'(dd)));
        end
    endtask

    task automatic rand_el();
        for (int i = 0; i < MAXN; i++) el_in[i] = $urandom;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          pv, pr, pf, pl;
        logic [7:0]  pd;
        logic [63:0] ena_cyc;
        int          kind;

        for (int i = 0; i < MAXN; i++) begin off_m[i] = 0; el_in[i] = 0; end

        // Handshake monitor: compares each accepted byte against the queue head.
        fork
            begin
                pv = 0; pr = 0; pf = 0; pl = 0; pd = 0;
                forever begin
                    exp_t        e;
                    logic [7:0]  xd;
                    @(negedge clk);
                    if (!reset_n) begin pv = 0; continue; end
                    if (pv && !pr)
                        chk("hold_stable", {52'd0, m_cmd_valid, m_cmd_first, m_cmd_last, m_cmd_data},
                            {52'd0, 1'b1, pf, pl, pd});
                    if (m_cmd_valid && !pv) begin
                        t0_exp = current_time - 64'd2;
                        first_valid_cyc = cyc;
                    end
                    if (m_cmd_valid && m_cmd_ready) begin
                        if (q.size() == 0) begin
                            chk("unexpected_byte", {54'd0, m_cmd_first, m_cmd_last, m_cmd_data}, 64'd0);
                        end else begin
                            e  = q.pop_front();
                            xd = e.is_time ? 8'(t0_exp >> (8 * e.tbyte)) : e.data;
                            chk("cmd_byte", {54'd0, m_cmd_first, m_cmd_last, m_cmd_data},
                                {54'd0, e.first, e.last, xd});
                            if (e.first) tx_ct = current_time[31:0];
                            if (e.last) begin last_seen = 1; last_hs_cyc = cyc; end
                        end
                    end
                    pv = m_cmd_valid; pr = m_cmd_ready; pf = m_cmd_first; pl = m_cmd_last; pd = m_cmd_data;
                end
            end
        join_none

        repeat (3) step();
        chk("reset_outputs", {53'd0, m_cmd_valid, m_cmd_first, m_cmd_last, busy, done, error, overrun, m_cmd_data},
            64'd0);
        reset_n = 1;
        step();

        // First packet timing and content
        period = 32'd100; node_count = 8'd2; rdy_mode = 1;
        push_pkt();
        enable = 1; ena_cyc = cyc;
        wait_pkt();
        chk("first_valid_latency", first_valid_cyc - ena_cyc, 64'd102);

        // Known offsets: rtt 1000, elapsed 900/400 -> 50/300
        el_in[0] = 32'd900; el_in[1] = 32'd400;
        do_resp(32'd1000, 0, 0);
        chk("offset_model_n1", {32'd0, off_m[0]}, 64'd50);
        push_pkt();
        wait_pkt();

        // Override pulse during WAIT_RES
        step();
        override_req = 1; step(); override_req = 0; ovr_m = 1;
        rand_el(); do_resp($urandom, 1, 0);
        push_pkt(); wait_pkt();
        rand_el(); do_resp($urandom, 0, 1);
        push_pkt();

        // Backpressure
        rdy_mode = 2;
        wait_pkt();
        rand_el(); do_resp($urandom, 0, 0);
        rdy_mode = 1;
        chk("no_overrun_yet", {63'd0, overrun}, 64'd0);

        // Response error
        push_pkt(); wait_pkt();
        step();
        res_rx_error = 1; step(); res_rx_error = 0;
        chk("error_set", {62'd0, error, done}, 64'h2);
        chk("busy_after_error", {63'd0, busy}, 64'd0);
        node_count = 8'd3;
        push_pkt(); wait_pkt();
        chk("error_cleared", {63'd0, error}, 64'd0);

        // Timeout with no response
        for (int i = 0; i < TMO + 50 && !error; i++) step();
        chk("timeout_cycles", cyc - last_hs_cyc, 64'(TMO + 1));
        push_pkt(); wait_pkt();
        chk("error_cleared_2", {63'd0, error}, 64'd0);
        rand_el(); do_resp($urandom, 1, 0);

        // Randomised transactions
        for (int it = 0; it < 14; it++) begin
            node_count = 8'($urandom_range(0, 10));
            rdy_mode   = ($urandom % 2) ? 1 : 3;
            push_pkt(); wait_pkt();
            rdy_mode = 1;
            kind = $urandom_range(0, 5);
            if (kind == 0) begin
                step(); res_rx_error = 1; step(); res_rx_error = 0;
                chk("rand_error", {62'd0, error, busy}, 64'h2);
            end else begin
                if (kind == 1) begin override_req = 1; step(); override_req = 0; ovr_m = 1; end
                rand_el();
                do_resp($urandom, 1'($urandom % 2), kind == 2);
            end
        end

        // Overrun with stalled output, then reset mid-SEND
        enable = 0;
        step();
        period = 32'd5; rdy_mode = 0;
        enable = 1;
        repeat (30) step();
        chk("overrun_set", {62'd0, overrun, m_cmd_valid}, 64'h3);
        reset_n = 0;
        #1;
        chk("reset_mid_send", {52'd0, m_cmd_valid, busy, m_cmd_first, m_cmd_last, overrun, m_cmd_data},
            64'd0);
        enable = 0;
        q.delete();
        for (int i = 0; i < MAXN; i++) off_m[i] = 0;
        ovr_m = 0;
        repeat (2) step();
        reset_n = 1;
        period = 32'd100; rdy_mode = 1; node_count = 8'd8;
        step();
        push_pkt();
        enable = 1;
        wait_pkt();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
